// File: rtl/cpu_isa_pkg.sv
// ISA constants and symbolic op kinds shared by the instruction loader and decoder.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package cpu_isa_pkg;

  // Symbolic instruction kinds as presented on the loader's input stream.
  typedef enum logic [2:0] {
    OPK_ADD  = 3'd0,
    OPK_SLT  = 3'd1,
    OPK_BEQ  = 3'd2,
    OPK_LW   = 3'd3,
    OPK_SW   = 3'd4,
    OPK_ADDI = 3'd5,
    OPK_J    = 3'd6,
    OPK_HALT = 3'd7
  } op_kind_e;

  // Primary opcodes (instruction bits [31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-type function codes (instruction bits [5:0]).
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SLT = 6'h2A;

  // Canonical HALT word; also used to terminate memory on overflow.
  localparam logic [31:0] HALT_WORD = {OP_HALT, 26'd0};

  // Loader control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } load_state_e;

  function automatic logic [31:0] enc_rtype(input logic [5:0] funct,
                                            input logic [4:0] rs,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_itype(input logic [5:0]  opc,
                                            input logic [4:0]  rs,
                                            input logic [4:0]  rt,
                                            input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_field_encoder.sv
// Packs symbolic instruction fields into a 32-bit MIPS-subset word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   op_i   - op kind (cpu_isa_pkg::op_kind_e encoding)
//   rs_i, rt_i, rd_i - register fields; rd_i only used by R-type kinds
//   imm_i  - immediate; [15:0] for I-type kinds, all 26 bits for J
//   word_o - encoded instruction word
module inst_field_encoder
  import cpu_isa_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = HALT_WORD;
    case (op_kind_e'(op_i))
      OPK_ADD:  word_o = enc_rtype(F_ADD, rs_i, rt_i, rd_i);
      OPK_SLT:  word_o = enc_rtype(F_SLT, rs_i, rt_i, rd_i);
      OPK_BEQ:  word_o = enc_itype(OP_BEQ,  rs_i, rt_i, imm_i[15:0]);
      OPK_LW:   word_o = enc_itype(OP_LW,   rs_i, rt_i, imm_i[15:0]);
      OPK_SW:   word_o = enc_itype(OP_SW,   rs_i, rt_i, imm_i[15:0]);
      OPK_ADDI: word_o = enc_itype(OP_ADDI, rs_i, rt_i, imm_i[15:0]);
      OPK_J:    word_o = {OP_J, imm_i};
      OPK_HALT: word_o = HALT_WORD;
      default:  word_o = HALT_WORD;
    endcase
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams symbolic instructions into instruction memory from address 0, encoding each word.
// Latency: one cycle from accepted handshake to the imem write strobe; one word per cycle.
// Backpressure: in_ready is high only while loading; drops after HALT or memory overflow.
//
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   start               - pulse; begins a new load at address 0 (ignored mid-load)
//   in_valid/in_ready   - input handshake for in_op/in_rs/in_rt/in_rd/in_imm
//   imem_we/addr/wdata  - registered single-cycle instruction-memory write
//   busy                - loading, or a write still on the memory port
//   done / error        - sticky: HALT written / memory filled without HALT
//   count               - words written during the current load
module inst_mem_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [31:0] enc_word;
  logic        hs;
  logic        is_halt;
  logic        at_last;

  inst_field_encoder u_enc (
    .op_i   (in_op),
    .rs_i   (in_rs),
    .rt_i   (in_rt),
    .rd_i   (in_rd),
    .imm_i  (in_imm),
    .word_o (enc_word)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign hs       = in_valid & in_ready;
  assign is_halt  = (op_kind_e'(in_op) == OPK_HALT);
  assign at_last  = (ptr_q == PTR_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      ST_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          count_d = count_q + 1'b1;
          if (is_halt) begin
            wdata_d = enc_word;
            done_d  = 1'b1;
            state_d = ST_DONE;
            // The pointer saturates at the last word rather than wrapping.
            if (!at_last) ptr_d = ptr_q + 1'b1;
          end else if (at_last) begin
            // Last slot taken by a non-HALT: terminate memory with HALT instead.
            wdata_d = HALT_WORD;
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            wdata_d = enc_word;
            ptr_d   = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERROR all restart the same way.
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign error      = error_q;
  assign count      = count_q;
  assign busy       = (state_q == ST_LOAD) | we_q;

endmodule
